// File: rtl/enigma_pkg.sv
// enigma_pkg
// Shared definitions for the rotor-chain controller: alphabet constants,
// the abort character, the controller state type and the letter-index type
// used by the stepping odometer. The is_letter helper classifies a host
// character as an upper-case ASCII letter.
package enigma_pkg;

  localparam int          NUM_LETTERS     = 26;
  localparam logic [7:0]  ASCII_A         = 8'h41;
  localparam logic [7:0]  ASCII_Z         = 8'h5A;
  localparam logic [7:0]  ERR_CHAR        = 8'h3F;
  localparam logic [4:0]  LAST_LETTER_IDX = 5'(NUM_LETTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    ISSUE,
    WAIT,
    OUT
  } ctrl_state_t;

  typedef logic [4:0] letter_idx_t;

  // Only 'A'..'Z' are enciphered; everything else bypasses the rotors.
  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/enigma_if.sv
// enigma_if
// Bundles the host handshake and the rotor-chain bus seen by the controller.
// Host side : cfg_set, in_valid/in_ready/in_char/in_dec,
//             out_valid/out_ready/out_char/out_err
// Rotor side: rot_set, rot_en, rot_valid, rot_din, rot_dec (to rotors),
//             rot_done, rot_dout (from rotors; rotor k at [8k+7:8k])
// master = the controller, slave = host plus rotor instances.
interface enigma_if #(
  parameter int NUM_ROTORS = 3
);
  import enigma_pkg::*;

  logic                    cfg_set;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_char;
  logic                    in_dec;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_char;
  logic                    out_err;
  logic                    rot_set;
  logic [NUM_ROTORS-1:0]   rot_en;
  logic [NUM_ROTORS-1:0]   rot_valid;
  logic [7:0]              rot_din;
  logic                    rot_dec;
  logic [NUM_ROTORS-1:0]   rot_done;
  logic [8*NUM_ROTORS-1:0] rot_dout;

  modport master (
    input  cfg_set, in_valid, in_char, in_dec, out_ready, rot_done, rot_dout,
    output in_ready, out_valid, out_char, out_err,
           rot_set, rot_en, rot_valid, rot_din, rot_dec
  );

  modport slave (
    output cfg_set, in_valid, in_char, in_dec, out_ready, rot_done, rot_dout,
    input  in_ready, out_valid, out_char, out_err,
           rot_set, rot_en, rot_valid, rot_din, rot_dec
  );

endinterface

// File: rtl/enigma_step_odometer.sv
// enigma_step_odometer
// Per-rotor position counters (0..25) chained like an odometer.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_step         : advance the odometer this cycle
//   i_clear        : return every counter to 0 (has priority over i_step)
//   o_en           : per-rotor step pulse, only driven while i_step is high
module enigma_step_odometer
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_step,
  input  logic                  i_clear,
  output logic [NUM_ROTORS-1:0] o_en
);

  letter_idx_t           r_cnt [NUM_ROTORS];
  logic [NUM_ROTORS-1:0] w_carry;

  // Rotor k moves when every lower rotor sits at its last position;
  // rotor 0 always moves.
  always_comb begin
    logic v_all_last;
    w_carry    = '0;
    v_all_last = 1'b1;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      w_carry[k] = v_all_last;
      v_all_last = v_all_last & (r_cnt[k] == LAST_LETTER_IDX);
    end
  end

  assign o_en = i_step ? w_carry : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_ROTORS; k++) r_cnt[k] <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < NUM_ROTORS; k++) r_cnt[k] <= '0;
    end else if (i_step) begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        if (w_carry[k]) begin
          r_cnt[k] <= (r_cnt[k] == LAST_LETTER_IDX) ? '0 : r_cnt[k] + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/enigma_ctrl.sv
// enigma_ctrl
// Initiator-side sequencer for the rotor chain. Accepts one character from
// the host, steps the rotors, walks the character through every rotor stage
// (0..N-1 for encode, N-1..0 for decode) and returns the result. A stage that
// never reports done within TIMEOUT wait cycles aborts the character with '?'
// and the error flag set.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus          : enigma_if master view (host handshake + rotor bus)
module enigma_ctrl
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic     clk,
  input  logic     reset_n,
  enigma_if.master bus
);

  localparam int SW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_ROTORS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  ctrl_state_t           r_state, w_state_nxt;
  logic [7:0]            r_char, w_char_nxt;
  logic                  r_dec, w_dec_nxt;
  logic [SW-1:0]         r_stage, w_stage_nxt;
  logic [TW-1:0]         r_tmo, w_tmo_nxt;
  logic                  r_err, w_err_nxt;

  logic                  w_idle_cfg;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_step;
  logic                  w_final;
  logic [SW+2:0]         w_dout_base;
  logic [NUM_ROTORS-1:0] w_rot_en;
  logic [NUM_ROTORS-1:0] w_rot_valid;

  // A config strobe only counts while idle, and it blocks acceptance that
  // cycle so a character never steps counters that are being cleared.
  assign w_idle_cfg = (r_state == IDLE) & bus.cfg_set;
  assign w_in_ready = (r_state == IDLE) & ~bus.cfg_set;
  assign w_accept   = w_in_ready & bus.in_valid;
  assign w_step     = (r_state == STEP);

  enigma_step_odometer #(
    .NUM_ROTORS (NUM_ROTORS)
  ) u_odometer (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_step  (w_step),
    .i_clear (w_idle_cfg),
    .o_en    (w_rot_en)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_char  <= 8'h00;
      r_dec   <= 1'b0;
      r_stage <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_char  <= w_char_nxt;
      r_dec   <= w_dec_nxt;
      r_stage <= w_stage_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and datapath updates. The last stage depends on direction:
  // decode walks downward and finishes at stage 0.
  always_comb begin
    w_state_nxt = r_state;
    w_char_nxt  = r_char;
    w_dec_nxt   = r_dec;
    w_stage_nxt = r_stage;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    w_rot_valid = '0;
    w_dout_base = {r_stage, 3'b000};
    w_final     = r_dec ? (r_stage == '0) : (r_stage == LAST_STAGE);

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_char_nxt  = bus.in_char;
          w_dec_nxt   = bus.in_dec;
          w_stage_nxt = bus.in_dec ? LAST_STAGE : '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = is_letter(bus.in_char) ? STEP : OUT;
        end
      end
      STEP: begin
        w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_rot_valid[r_stage] = 1'b1;
        w_tmo_nxt            = '0;
        w_state_nxt          = WAIT;
      end
      WAIT: begin
        if (bus.rot_done[r_stage]) begin
          w_char_nxt = bus.rot_dout[w_dout_base +: 8];
          if (w_final) begin
            w_state_nxt = OUT;
          end else begin
            w_stage_nxt = r_dec ? (r_stage - SW'(1)) : (r_stage + SW'(1));
            w_state_nxt = ISSUE;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_char_nxt  = ERR_CHAR;
          w_state_nxt = OUT;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_char  = (r_state == OUT) ? r_char : 8'h00;
  assign bus.out_err   = (r_state == OUT) & r_err;
  assign bus.rot_set   = w_idle_cfg;
  assign bus.rot_en    = w_rot_en;
  assign bus.rot_valid = w_rot_valid;
  assign bus.rot_din   = (r_state == ISSUE) ? r_char : 8'h00;
  assign bus.rot_dec   = r_dec;

endmodule

// File: doc/enigma_ctrl.md
# enigma_ctrl

Initiator-side sequencer for the rotor chain: accepts one ASCII character at a time from the host, issues the per-character stepping pulses, and walks the character through NUM_ROTORS rotor stages over their set/en/valid/din/dec → done/dout interface. Encode order is 0..N-1 and decode order is N-1..0. It returns the result over a valid/ready output handshake. It sits between the host/UART front end and the rotor instances. It owns stepping policy, stage ordering and done-timeout recovery.

## Interface
- NUM_ROTORS, 3, number of rotor stages driven (1..8)
- TIMEOUT, 64, max WAIT cycles per stage before abort (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_set  in  1  host config strobe; forwarded to rotors, clears step counters
- in_valid  in  1  host character valid
- in_ready  out  1  controller can accept a character
- in_char  in  8  ASCII character
- in_dec  in  1  0 = encode, 1 = decode
- out_valid  out  1  result valid
- out_ready  in  1  host accepts result
- out_char  out  8  result character
- out_err  out  1  result aborted by timeout (qualified by out_valid)
- rot_set  out  1  broadcast config strobe to all rotors
- rot_en  out  NUM_ROTORS  per-rotor step pulse
- rot_valid  out  NUM_ROTORS  per-rotor character-issue pulse
- rot_din  out  8  character to the addressed rotor (shared bus)
- rot_dec  out  1  direction to all rotors
- rot_done  in  NUM_ROTORS  per-rotor completion pulse
- rot_dout  in  8*NUM_ROTORS  per-rotor result, rotor k at [8k+7:8k]

## Operation
- States: IDLE, STEP, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1 unless cfg_set=1.
  - cfg_set in IDLE drives rot_set=1 that cycle (combinational pass-through) and clears all step counters. cfg_set outside IDLE is ignored.
  - An accept is in_valid & in_ready. On accept, latch in_char into the working char and in_dec into rot_dec.
  - A letter ('A'..'Z', 8'h41..8'h5A) goes to STEP. A non-letter goes directly to OUT unchanged, with no stepping.
- STEP (1 cycle):
  - Odometer: 5-bit counter cnt[k] per rotor, range 0..25.
  - rot_en[0]=1 always. rot_en[k]=1 iff cnt[j]==25 for all j<k.
  - Every counter with rot_en[k]=1 increments, wrapping 25→0. Stepping is identical in both directions.
- Stage order: first stage is 0 (encode) or N-1 (decode).
- ISSUE (1 cycle): rot_valid[stage]=1 and rot_din=working char. Clear the timeout counter.
- WAIT:
  - rot_done[stage]=1: working char ← rot_dout[stage]. If this was the last stage, go to OUT; otherwise advance the stage and go to ISSUE.
  - Done bits from other rotors are ignored.
  - The timeout counter reaches TIMEOUT without done: set the err flag and working char ← 8'h3F, then go to OUT.
- OUT: out_valid=1, out_char=working char, out_err=err flag. Hold until out_ready=1, then go to IDLE and clear the err flag.

## Timing
- Reset values:
  - State IDLE; all cnt=0; stage=0; err=0.
  - out_valid=0, out_char=8'h00, out_err=0.
  - rot_en=0, rot_valid=0, rot_din=8'h00, rot_dec=0, rot_set=0.
  - in_ready=1 once reset_n is high.
- Cycle numbering: accept edge = cycle 0.
  - Letter: STEP at cycle 1, first ISSUE at cycle 2.
  - With rot_done in the first WAIT cycle, each stage takes 2 cycles, so out_valid rises at cycle 2+2·NUM_ROTORS (cycle 8 for N=3).
  - Non-letter: out_valid at cycle 1.
- rot_en and rot_valid are single-cycle pulses and never asserted together.
- in_ready=0 from the cycle after accept until the cycle after the out handshake. No overlap between characters.
- out_char and out_err are stable while out_valid=1 & out_ready=0.
- Reset asserted mid-operation aborts immediately to reset values. The partial character is discarded and counters clear.
- Simultaneous cfg_set and in_valid in IDLE: cfg_set wins, in_ready=0 and no accept that cycle.

## Structure
- Shared package enigma_pkg:
  - NUM_LETTERS=26, ASCII_A=8'h41, ASCII_Z=8'h5A, ERR_CHAR=8'h3F.
  - State enum ctrl_state_t.
  - 5-bit letter-index typedef.
- Sub-module enigma_step_odometer holds the cnt array. Inputs: step, clear. Output: the rot_en vector. Parameter: NUM_ROTORS.

## Test plan
- Reset then encode 'A': bench rotors return din+1 after 1 cycle → out_char 'D' at cycle 8, rot_en=3'b001, rot_valid pulses in order 0,1,2.
- Decode 'D' with the same bench model (din−1) → rot_valid pulses in order 2,1,0; out_char 'A'; rot_dec=1 throughout.
- Stepping: 26 letters after reset → rot_en=3'b011 on the 26th; 676 letters → rot_en=3'b111 on the 676th. cfg_set then restarts at rot_en=3'b001.
- Non-letter '5' (8'h35) → out_char 8'h35 at cycle 1, no rot_en/rot_valid pulses, counters unchanged.
- Rotor 1 never asserts done → out_err=1, out_char 8'h3F; the next character processes normally with out_err=0.
- out_ready held low 10 cycles → out_char stable, in_ready=0, in_valid ignored. Reset asserted mid-WAIT → all outputs return to reset values.
